// File: rtl/debug_display_pager_if.sv
// Bundle between the debug pager and the board top level: channel words, keys, freeze in;
// selected page, 7-segment digits and change pulse out.
// master = board/top-level side (drives keys and channel data), slave = the pager itself.
interface debug_display_pager_if #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 8,
  parameter int NUM_DIGITS = 4
);
  localparam int PAGE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_W-1:0] ChData;   // channel c at [c*DATA_W +: DATA_W]
  logic                     KeyNext;  // raw pushbutton, active-low
  logic                     KeyPrev;  // raw pushbutton, active-low
  logic                     Freeze;   // 1 = hold displayed value
  logic [PAGE_W-1:0]        Page;     // selected channel
  logic [NUM_DIGITS*7-1:0]  HEX;      // digit i at [i*7 +: 7], active-low g..a
  logic [6:0]               HEXPage;  // low nibble of Page, same encoding
  logic                     Changed;  // one-cycle pulse after each page change

  modport master (
    output ChData, KeyNext, KeyPrev, Freeze,
    input  Page, HEX, HEXPage, Changed
  );

  modport slave (
    input  ChData, KeyNext, KeyPrev, Freeze,
    output Page, HEX, HEXPage, Changed
  );
endinterface

// File: rtl/debug_display_pager.sv
// Debug pager: picks one of NUM_CH words, latches it and shows its low nibbles on 7-seg digits.
// Latency: key press to Page update is DEBOUNCE_CYCLES+3 edges; ChData to HEX is one edge.
// No backpressure: one page step per debounced press, presses during debounce are not queued.
// Ports: Clock, Reset (sync, active-high); bus (slave modport) carries ChData, KeyNext,
// KeyPrev, Freeze in and Page, HEX, HEXPage, Changed out.
module debug_display_pager #(
  parameter int DATA_W          = 16,
  parameter int NUM_CH          = 8,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  debug_display_pager_if.slave  bus
);
  localparam int PAGE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int EXT_W  = (NUM_DIGITS*4 > DATA_W) ? NUM_DIGITS*4 : DATA_W;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES-1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_CH-1);

  // Key index 0 = next, 1 = prev.
  logic [1:0]        raw_keys;
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0]        deb_q, deb_d;
  logic [1:0]        deb_dly_q;
  logic [1:0]        ev_q, ev_d;
  logic [CNT_W-1:0]  cnt_q [2];
  logic [CNT_W-1:0]  cnt_d [2];

  logic [PAGE_W-1:0] page_q, page_d;
  logic              changed_q, changed_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [DATA_W-1:0] sel_word;

  logic [EXT_W-1:0]          val_ext;
  logic [PAGE_W+3:0]         page_ext;
  logic [NUM_DIGITS*7-1:0]   hex_segs;

  assign raw_keys = {bus.KeyPrev, bus.KeyNext};

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Debounce: the synchronised level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles before it is accepted; any agreement restarts the count.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      deb_d[k] = deb_q[k];
      cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          deb_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
    // Press = accepted level fell 1->0 on the previous edge; releases are ignored.
    ev_d = deb_dly_q & ~deb_q;
  end

  // Channel select.
  always_comb begin
    sel_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (page_q == PAGE_W'(c)) sel_word = bus.ChData[c*DATA_W +: DATA_W];
    end
  end

  // Page stepping; simultaneous next+prev cancel out and raise no pulse.
  always_comb begin
    page_d    = page_q;
    changed_d = 1'b0;
    if (ev_q[0] && !ev_q[1]) begin
      page_d    = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
      changed_d = 1'b1;
    end else if (ev_q[1] && !ev_q[0]) begin
      page_d    = (page_q == '0) ? PAGE_LAST : page_q - 1'b1;
      changed_d = 1'b1;
    end
  end

  // While frozen, the cycle with Changed high grabs a single snapshot of the new channel.
  always_comb begin
    val_d = val_q;
    if (!bus.Freeze || changed_q) val_d = sel_word;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      deb_q     <= 2'b11;   // a key held through reset is seen as a fresh press
      deb_dly_q <= 2'b11;
      ev_q      <= 2'b00;
      for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
      page_q    <= '0;
      changed_q <= 1'b0;
      val_q     <= '0;
    end else begin
      sync1_q   <= raw_keys;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      ev_q      <= ev_d;
      for (int k = 0; k < 2; k++) cnt_q[k] <= cnt_d[k];
      page_q    <= page_d;
      changed_q <= changed_d;
      val_q     <= val_d;
    end
  end

  // Digits beyond DATA_W read zero-extended bits.
  assign val_ext  = EXT_W'(val_q);
  assign page_ext = {4'b0000, page_q};

  always_comb begin
    hex_segs = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_segs[i*7 +: 7] = seg7(val_ext[i*4 +: 4]);
    end
  end

  assign bus.HEX     = hex_segs;
  assign bus.HEXPage = seg7(page_ext[3:0]);
  assign bus.Page    = page_q;
  assign bus.Changed = changed_q;
endmodule

// File: tb/tb_debug_display_pager.sv
// Directed bench for debug_display_pager: table of display vectors plus hand-written
// sequences for reset-during-press, wrap-around, simultaneous keys, bounce and freeze.
// A second instance with DATA_W=8 checks zero-extended upper digits.
module tb_debug_display_pager;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_display_pager_if #(.DATA_W(16), .NUM_CH(8), .NUM_DIGITS(4)) ifa ();
  debug_display_pager_if #(.DATA_W(8),  .NUM_CH(2), .NUM_DIGITS(4)) ifb ();

  debug_display_pager #(.DATA_W(16), .NUM_CH(8), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut (
    .Clock(clk), .Reset(rst), .bus(ifa.slave)
  );
  debug_display_pager #(.DATA_W(8), .NUM_CH(2), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut_w (
    .Clock(clk), .Reset(rst), .bus(ifb.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] word;
    logic        frz;
    logic [27:0] hex;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One key press held 10 cycles then 10 released cycles; page must be stable for
  // 7 edges and step (or not) at the 8th edge (DEBOUNCE_CYCLES+3 with edge 0 first).
  task automatic press(input bit nxt, input bit prv, input logic [2:0] old_pg,
                       input logic [2:0] new_pg, input bit exp_chg, input string name);
    bit quiet;
    ifa.KeyNext = ~nxt;
    ifa.KeyPrev = ~prv;
    quiet = 1'b1;
    repeat (7) begin
      tick();
      if (ifa.Page !== old_pg || ifa.Changed !== 1'b0) quiet = 1'b0;
    end
    chk({name, " early"}, quiet, 1'b1);
    tick();
    chk({name, " page"}, ifa.Page, new_pg);
    chk({name, " changed"}, ifa.Changed, exp_chg);
    tick();
    chk({name, " pulse end"}, ifa.Changed, 1'b0);
    tick();
    ifa.KeyNext = 1'b1;
    ifa.KeyPrev = 1'b1;
    tick(10);
  endtask

  initial begin
    bit quiet;
    vecs[0] = '{16'h0123, 1'b0, {S0, S1, S2, S3}};
    vecs[1] = '{16'h4567, 1'b0, {S4, S5, S6, S7}};
    vecs[2] = '{16'h89AB, 1'b0, {S8, S9, SA, SB}};
    vecs[3] = '{16'hCDEF, 1'b0, {SC, SD, SE, SF}};
    vecs[4] = '{16'hBEEF, 1'b0, {SB, SE, SE, SF}};
    vecs[5] = '{16'h1234, 1'b1, {SB, SE, SE, SF}};
    vecs[6] = '{16'h0000, 1'b1, {SB, SE, SE, SF}};
    vecs[7] = '{16'h0000, 1'b0, {S0, S0, S0, S0}};

    rst = 1'b1;
    ifa.ChData = '0; ifa.KeyNext = 1'b1; ifa.KeyPrev = 1'b1; ifa.Freeze = 1'b0;
    ifb.ChData = {8'h00, 8'h3C}; ifb.KeyNext = 1'b1; ifb.KeyPrev = 1'b1; ifb.Freeze = 1'b0;
    tick(3);
    chk("reset page", ifa.Page, 3'd0);
    chk("reset changed", ifa.Changed, 1'b0);
    chk("reset hex", ifa.HEX, {S0, S0, S0, S0});
    chk("reset hexpage", ifa.HEXPage, S0);
    rst = 1'b0;

    // Narrow instance: upper digits of an 8-bit word read 0.
    tick();
    chk("width hex", ifb.HEX, {S0, S0, S3, SC});
    chk("width page", ifb.Page, 1'b0);

    // Display table on channel 0.
    for (int i = 0; i < 8; i++) begin
      ifa.ChData[15:0] = vecs[i].word;
      ifa.Freeze = vecs[i].frz;
      tick();
      chk($sformatf("vec%0d hex", i), ifa.HEX, vecs[i].hex);
    end
    ifa.Freeze = 1'b0;

    // Reset asserted mid-press; key stays held through release.
    ifa.KeyNext = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
    chk("midpress reset page", ifa.Page, 3'd0);
    chk("midpress reset changed", ifa.Changed, 1'b0);
    chk("midpress reset hex", ifa.HEX, {S0, S0, S0, S0});
    rst = 1'b0;
    quiet = 1'b1;
    repeat (7) begin
      tick();
      if (ifa.Page !== 3'd0 || ifa.Changed !== 1'b0) quiet = 1'b0;
    end
    chk("held key no early event", quiet, 1'b1);
    tick();
    chk("held key page", ifa.Page, 3'd1);
    chk("held key changed", ifa.Changed, 1'b1);
    chk("held key hexpage", ifa.HEXPage, S1);
    ifa.KeyNext = 1'b1;
    tick(12);

    // Forward wrap from page 0.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int p = 1; p <= 8; p++) begin
      press(1'b1, 1'b0, 3'((p - 1) % 8), 3'(p % 8), 1'b1, $sformatf("next%0d", p));
    end
    chk("wrap hexpage", ifa.HEXPage, S0);

    // Backward wrap, then both keys together.
    press(1'b0, 1'b1, 3'd0, 3'd7, 1'b1, "prev wrap");
    chk("prev hexpage", ifa.HEXPage, S7);
    press(1'b1, 1'b1, 3'd7, 3'd7, 1'b0, "both keys");

    // Bounce: 2-cycle low/high toggles for 20 cycles.
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ifa.KeyNext = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        tick();
        if (ifa.Page !== 3'd7 || ifa.Changed !== 1'b0) quiet = 1'b0;
      end
    end
    ifa.KeyNext = 1'b1;
    repeat (15) begin
      tick();
      if (ifa.Page !== 3'd7 || ifa.Changed !== 1'b0) quiet = 1'b0;
    end
    chk("bounce no change", quiet, 1'b1);

    // Freeze on page 2.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    press(1'b1, 1'b0, 3'd0, 3'd1, 1'b1, "to page1");
    press(1'b1, 1'b0, 3'd1, 3'd2, 1'b1, "to page2");
    ifa.ChData[2*16 +: 16] = 16'hBEEF;
    ifa.Freeze = 1'b0;
    tick();
    chk("live beef", ifa.HEX, {SB, SE, SE, SF});
    ifa.Freeze = 1'b1;
    ifa.ChData[2*16 +: 16] = 16'h1234;
    tick(3);
    chk("frozen beef", ifa.HEX, {SB, SE, SE, SF});
    ifa.ChData[3*16 +: 16] = 16'h00A5;
    ifa.KeyNext = 1'b0;
    tick(8);
    chk("freeze page3", ifa.Page, 3'd3);
    chk("freeze changed", ifa.Changed, 1'b1);
    chk("freeze before snapshot", ifa.HEX, {SB, SE, SE, SF});
    tick();
    chk("freeze snapshot", ifa.HEX, {S0, S0, SA, S5});
    ifa.KeyNext = 1'b1;
    ifa.ChData[3*16 +: 16] = 16'hFFFF;
    tick(5);
    chk("freeze holds snapshot", ifa.HEX, {S0, S0, SA, S5});
    ifa.Freeze = 1'b0;
    tick();
    chk("unfreeze live", ifa.HEX, {SF, SF, SF, SF});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
